// File: rtl/lcv_mul_acc_pipe.sv
// lcv_mul_acc_pipe: three-stage signed multiply-accumulate with valid/ready on both sides
// Ports:
//   clk, rst (async active-low)
//   in_valid/in_ready, in_a, in_b, in_sub, in_first, in_last : input beat stream
//   out_valid/out_ready, out_data, out_ovf                   : one result per in_last sequence
module lcv_mul_acc_pipe #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int ACC_WIDTH = 40,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic                 in_sub,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf
);
  localparam int PW = A_WIDTH + B_WIDTH;
  localparam logic [ACC_WIDTH-1:0] MAXV = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] MINV = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  if (PW > ACC_WIDTH) begin : g_width_check
    $error("lcv_mul_acc_pipe: A_WIDTH+B_WIDTH must not exceed ACC_WIDTH");
  end
  logic                       adv;
  logic                       s1_v, s1_sub, s1_first, s1_last;
  logic signed [A_WIDTH-1:0]  s1_a;
  logic signed [B_WIDTH-1:0]  s1_b;
  logic signed [PW-1:0]       prod;
  logic                       s2_v, s2_sub, s2_first, s2_last;
  logic        [PW-1:0]       s2_p;
  logic        [ACC_WIDTH-1:0] acc, res;
  logic                       sticky, ovf, sticky_nxt;
  logic        [ACC_WIDTH:0]  base, ext, sum;
  // One shared advance: a pending, untaken result freezes every stage
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign prod     = PW'(s1_a) * PW'(s1_b);
  always_comb begin
    base       = s2_first ? '0 : {acc[ACC_WIDTH-1], acc};
    ext        = {{(ACC_WIDTH+1-PW){s2_p[PW-1]}}, s2_p};
    sum        = s2_sub ? base - ext : base + ext;
    ovf        = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    res        = (ovf && SATURATE != 0) ? (sum[ACC_WIDTH] ? MINV : MAXV) : sum[ACC_WIDTH-1:0];
    sticky_nxt = (!s2_first && sticky) || ovf;
  end
  // acc/sticky are zeroed after a last beat, so the next beat starts from zero with or without first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v      <= 1'b0;
      s1_sub    <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_v      <= 1'b0;
      s2_sub    <= 1'b0;
      s2_first  <= 1'b0;
      s2_last   <= 1'b0;
      s2_p      <= '0;
      acc       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      s1_v      <= in_valid;
      s1_sub    <= in_sub;
      s1_first  <= in_first;
      s1_last   <= in_last;
      s1_a      <= in_a;
      s1_b      <= in_b;
      s2_v      <= s1_v;
      s2_sub    <= s1_sub;
      s2_first  <= s1_first;
      s2_last   <= s1_last;
      s2_p      <= prod;
      if (s2_v) begin
        acc    <= s2_last ? '0 : res;
        sticky <= !s2_last && sticky_nxt;
      end
      out_valid <= s2_v && s2_last;
      if (s2_v && s2_last) begin
        out_data <= res;
        out_ovf  <= sticky_nxt;
      end
    end
  end
endmodule

// File: doc/lcv_mul_acc_pipe.md
# lcv_mul_acc_pipe

Pipelined, parametrised signed multiply-accumulate engine with valid/ready handshakes on both sides. Accumulates a stream of `a*b` products, optionally subtracting per beat, and emits one accumulated result per `in_last`-terminated sequence. Saturating or wrapping accumulation is selectable, and overflow is flagged. It is the streaming successor of the fixed-width 16x16 MAC cells, for dot-product and filter datapaths with backpressure.

## Interface
- `A_WIDTH`, default 16: signed width of operand a.
- `B_WIDTH`, default 16: signed width of operand b.
- `ACC_WIDTH`, default 40: signed accumulator/result width. Elaboration error if `A_WIDTH+B_WIDTH > ACC_WIDTH`.
- `SATURATE`, default 1: 1 = clamp on overflow, 0 = two's-complement wrap.

- `clk`  in  1: sole clock, all state on rising edge.
- `rst`  in  1: reset, asynchronous assert, active-low (0 = reset); deassertion sampled on `clk`.
- `in_valid`  in  1: input beat valid.
- `in_ready`  out  1: engine accepts beat this cycle.
- `in_a`  in  `A_WIDTH`: signed operand a.
- `in_b`  in  `B_WIDTH`: signed operand b.
- `in_sub`  in  1: 1 = subtract product, 0 = add.
- `in_first`  in  1: beat starts a new sequence (base = 0, overflow cleared).
- `in_last`  in  1: beat ends sequence; result emitted.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer takes result.
- `out_data`  out  `ACC_WIDTH`: signed accumulated result.
- `out_ovf`  out  1: at least one overflow occurred within the sequence.

## Operation
- Three register stages: S1 captures operands and flags; S2 holds the full-precision signed product (`A_WIDTH+B_WIDTH` bits) with flags; S3 is the accumulator and output register.
- Global advance `adv = !out_valid || out_ready`. `in_ready = adv`, combinational. When `adv` = 0, S1, S2, the accumulator and the output are all frozen.
- Beat accepted when `in_valid && in_ready`. Non-accepted cycles inject a bubble (stage valid = 0). Bubbles never modify the accumulator.
- At S3 with a valid beat:
  - base = 0 if the beat has `first`, or if the previous accumulated beat had `last`; otherwise base = acc.
  - Sign-extended product is added or subtracted per `sub`.
  - The sum is computed in `ACC_WIDTH+1` bits.
- Overflow (sum outside the `ACC_WIDTH` signed range):
  - `SATURATE`=1: clamp to max/min.
  - `SATURATE`=0: keep the low `ACC_WIDTH` bits.
  - Either way, set the sticky ovf for the sequence. Later beats continue from the clamped or wrapped value.
- On a beat with `last`: `out_data` <= the new sum, `out_ovf` <= the sticky ovf (including this beat), `out_valid` <= 1. The accumulator and sticky ovf then restart from zero.
- `first` mid-sequence discards the partial sum and ovf with no output. `first && last` on one beat yields a single signed product.
- `out_valid` clears on the edge where `out_ready` = 1, unless a new `last` result loads on the same edge, in which case it stays 1 with new data.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_ovf` = 0.
  - All stage valids = 0, accumulator = 0, sticky ovf = 0.
  - `in_ready` = 1 during and after reset.
- Latency: a `last` beat accepted on edge E0 gives `out_valid` = 1 after edge E2, provided there is no stall.
- Throughput: one beat per cycle while `out_ready` = 1 or no result is pending.
- Result pending with `out_ready` = 0 stalls the pipeline from the next cycle. No beats are lost or duplicated.
- Back-to-back sequences, including a `last` followed immediately by `first`: no idle cycles required.
- Reset asserted mid-sequence: the partial sum, in-flight beats and any pending result are discarded asynchronously.

## Test plan
- Dot product, default parameters, no stalls. Beats (3,4,first), (-2,5), (7,-1), (10,10,last) -> `out_data`=95, `out_ovf`=0, `out_valid` rises 2 edges after the last beat is accepted, one result only.
- Same four beats with random `in_valid` gaps of 0-3 cycles -> identical 95 result, exactly one `out_valid` pulse.
- Subtract. Beats (100,1,first), (3,3,sub,last) -> 91. Then without `first`: (2,2,last) -> 4, proving the restart after `last`.
- Overflow, `ACC_WIDTH`=32. Beats (-32768,-32768) x3, first/last framed:
  - `SATURATE`=1 -> `out_data`=0x7FFFFFFF, `out_ovf`=1.
  - `SATURATE`=0 -> 0xC0000000, `out_ovf`=1.
  - Next sequence (1,1,first,last) -> 1, `out_ovf`=0.
- Backpressure. `out_ready`=0 for 5 cycles with a result pending and `in_valid` held high -> `in_ready`=0, `out_data` stable. After release, the queued sequence (5,6,first,last) -> 30 with no lost beats.
- Reset. Assert `rst`=0 mid-sequence after (9,9,first) -> outputs 0 immediately. After release, (5,6,first,last) -> 30, `out_ovf`=0.
